// File: rtl/mac_link_pkg.sv
// Shared constants, bus-select encodings and FSM state type for the MAC link host.
package mac_link_pkg;

   localparam int LANE_W        = 7;
   localparam int LANES         = 4;
   localparam int VEC_W         = LANE_W * LANES;
   localparam int BYTES_PER_VEC = 4;

   localparam logic [1:0] SEL_DATA = 2'b00;
   localparam logic [1:0] SEL_IDLE = 2'b01;
   localparam logic [1:0] SEL_READ = 2'b10;
   localparam logic [1:0] SEL_WGT  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_D,
      ST_SEND_W,
      ST_SETTLE,
      ST_READ,
      ST_RESP
   } state_e;

   typedef logic [VEC_W-1:0] vec_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mac_link_host_if.sv
// Request/response handshakes plus the peripheral byte bus of the MAC link host.
interface mac_link_host_if;
   import mac_link_pkg::*;

   logic        req_valid;
   logic        req_ready;
   vec_t        req_data;
   vec_t        req_weights;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [7:0]  bus_out;
   logic [1:0]  bus_sel;
   logic [7:0]  bus_in;
   logic        busy;

   // slave = the host controller; master = sequencer and peripheral around it
   modport slave (
      input  req_valid, req_data, req_weights, rsp_ready, bus_in,
      output req_ready, rsp_valid, rsp_result, bus_out, bus_sel, busy
   );

   modport master (
      output req_valid, req_data, req_weights, rsp_ready, bus_in,
      input  req_ready, rsp_valid, rsp_result, bus_out, bus_sel, busy
   );

endinterface

// File: rtl/mac_link_ser.sv
// Loadable 28-bit to 4-byte MSB-first serializer; byte_o is the byte the next take consumes.
module mac_link_ser
   import mac_link_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       take_i,
   input  vec_t       vec_i,
   output logic [7:0] byte_o
);

   localparam int PAD_W = 8 * BYTES_PER_VEC;

   logic [PAD_W-1:0] padded;
   logic [PAD_W-1:0] sh_q;
   logic [PAD_W-1:0] sh_d;

   assign padded = {{(PAD_W-VEC_W){1'b0}}, vec_i};

   // A load that is also a take bypasses the register, so byte 0 leaves on the loading edge.
   assign byte_o = load_i ? padded[PAD_W-1 -: 8] : sh_q[PAD_W-1 -: 8];

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = take_i ? (padded << 8) : padded;
      end else if (take_i) begin
         sh_d = sh_q << 8;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

endmodule

// File: rtl/mac_link_host.sv
// Host controller: serializes data/weights to the MAC peripheral, waits, reads back the 16-bit result.
module mac_link_host
   import mac_link_pkg::*;
#(
   parameter int RESULT_LAT = 2,
   parameter int READ_LAT   = 2
) (
   input  logic            clk,
   input  logic            rst,
   mac_link_host_if.slave  link
);

   localparam int CNT_MAX = max_int(BYTES_PER_VEC, max_int(RESULT_LAT, READ_LAT + 1));
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [CW-1:0] BEAT_LAST   = CW'(BYTES_PER_VEC - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(RESULT_LAT - 1);
   localparam logic [CW-1:0] HI_CYC      = CW'(READ_LAT - 1);
   localparam logic [CW-1:0] LO_CYC      = CW'(READ_LAT);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      bus_out_q;
   logic [1:0]      bus_sel_q;
   logic            rsp_valid_q;
   logic [15:0]     rsp_result_q;
   logic [7:0]      hi_q;

   logic            accept;
   logic            d_take;
   logic            w_take;
   logic [7:0]      d_byte;
   logic [7:0]      w_byte;

   assign accept = (state_q == ST_IDLE) && link.req_valid;
   assign d_take = accept || ((state_q == ST_SEND_D) && (cnt_q != BEAT_LAST));
   // The weight stream starts on the edge that ends the last data beat.
   assign w_take = ((state_q == ST_SEND_D) && (cnt_q == BEAT_LAST)) ||
                   ((state_q == ST_SEND_W) && (cnt_q != BEAT_LAST));

   mac_link_ser u_ser_data (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .take_i (d_take),
      .vec_i  (link.req_data),
      .byte_o (d_byte)
   );

   mac_link_ser u_ser_wgt (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .take_i (w_take),
      .vec_i  (link.req_weights),
      .byte_o (w_byte)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bus_out_q    <= '0;
         bus_sel_q    <= SEL_IDLE;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         hi_q         <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q   <= ST_SEND_D;
                  cnt_q     <= '0;
                  bus_sel_q <= SEL_DATA;
                  bus_out_q <= d_byte;
               end
            end
            ST_SEND_D: begin
               if (cnt_q == BEAT_LAST) begin
                  state_q   <= ST_SEND_W;
                  cnt_q     <= '0;
                  bus_sel_q <= SEL_WGT;
                  bus_out_q <= w_byte;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  bus_out_q <= d_byte;
               end
            end
            ST_SEND_W: begin
               if (cnt_q == BEAT_LAST) begin
                  state_q   <= ST_SETTLE;
                  cnt_q     <= '0;
                  bus_sel_q <= SEL_IDLE;
                  bus_out_q <= '0;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  bus_out_q <= w_byte;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_q   <= ST_READ;
                  cnt_q     <= '0;
                  bus_sel_q <= SEL_READ;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_READ: begin
               if (cnt_q == HI_CYC) begin
                  hi_q <= link.bus_in;
               end
               if (cnt_q == LO_CYC) begin
                  state_q      <= ST_RESP;
                  cnt_q        <= '0;
                  bus_sel_q    <= SEL_IDLE;
                  rsp_valid_q  <= 1'b1;
                  rsp_result_q <= {hi_q, link.bus_in};
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RESP: begin
               if (link.rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               bus_sel_q <= SEL_IDLE;
            end
         endcase
      end
   end

   assign link.req_ready  = (state_q == ST_IDLE);
   assign link.busy       = (state_q != ST_IDLE);
   assign link.bus_out    = bus_out_q;
   assign link.bus_sel    = bus_sel_q;
   assign link.rsp_valid  = rsp_valid_q;
   assign link.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mac_link_host.sv
// Directed bench: two hosts (default and RESULT_LAT=1/READ_LAT=3) run in lockstep against bus models.
module tb_mac_link_host;
   import mac_link_pkg::*;

   localparam int RL_A  = 2;
   localparam int RDL_A = 2;
   localparam int RL_B  = 1;
   localparam int RDL_B = 3;

   typedef struct {
      vec_t        data;
      vec_t        wgt;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [31:0] exp_d;
      logic [31:0] exp_w;
      logic [15:0] exp_res;
      int          bp;
   } txn_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   tick  = 0;
   int   acc_tick = 0;
   int   rd_idx_a;
   int   rd_idx_b;
   logic [7:0] model_hi = 8'h00;
   logic [7:0] model_lo = 8'h00;
   txn_t tbl [3];

   mac_link_host_if ifa ();
   mac_link_host_if ifb ();

   mac_link_host #(.RESULT_LAT(RL_A), .READ_LAT(RDL_A)) dut_a (.clk(clk), .rst(rst), .link(ifa));
   mac_link_host #(.RESULT_LAT(RL_B), .READ_LAT(RDL_B)) dut_b (.clk(clk), .rst(rst), .link(ifb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) tick <= tick + 1;

   // Peripheral read model: hi in read cycle RDL-1 (0-based), lo in cycle RDL, junk otherwise.
   function automatic logic [7:0] model_byte(input logic [1:0] sel, input int idx, input int rdl,
                                             input logic [7:0] hi, input logic [7:0] lo);
      if (sel != SEL_READ) return 8'h00;
      if (idx == rdl - 1) return hi;
      if (idx == rdl) return lo;
      return 8'hEE;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_idx_a <= 0;
         rd_idx_b <= 0;
      end else begin
         rd_idx_a <= (ifa.bus_sel == SEL_READ) ? rd_idx_a + 1 : 0;
         rd_idx_b <= (ifb.bus_sel == SEL_READ) ? rd_idx_b + 1 : 0;
      end
   end

   assign ifa.bus_in = model_byte(ifa.bus_sel, rd_idx_a, RDL_A, model_hi, model_lo);
   assign ifb.bus_in = model_byte(ifb.bus_sel, rd_idx_b, RDL_B, model_hi, model_lo);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // sel 00 may only appear in cycles 1..4 after the latest accept
   always @(negedge clk) begin
      if (!rst) begin
         if (ifa.bus_sel == SEL_DATA)
            check("a_sel00_window", ((tick - acc_tick + 1) >= 1) && ((tick - acc_tick + 1) <= 4), 1);
         if (ifb.bus_sel == SEL_DATA)
            check("b_sel00_window", ((tick - acc_tick + 1) >= 1) && ((tick - acc_tick + 1) <= 4), 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   function automatic logic [1:0] exp_sel(input int c, input int rl, input int rdl);
      if (c >= 1 && c <= 4) return SEL_DATA;
      if (c >= 5 && c <= 8) return SEL_WGT;
      if (c >= 9 + rl && c <= 9 + rl + rdl) return SEL_READ;
      return SEL_IDLE;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic v, input vec_t d, input vec_t w);
      ifa.req_valid = v;  ifa.req_data = d;  ifa.req_weights = w;
      ifb.req_valid = v;  ifb.req_data = d;  ifb.req_weights = w;
   endtask

   task automatic set_rsp_ready(input logic r);
      ifa.rsp_ready = r;
      ifb.rsp_ready = r;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_sel"}, ifa.bus_sel, SEL_IDLE);
      check({tag, "_b_sel"}, ifb.bus_sel, SEL_IDLE);
      check({tag, "_a_bus_out"}, ifa.bus_out, 0);
      check({tag, "_a_req_ready"}, ifa.req_ready, 1);
      check({tag, "_b_req_ready"}, ifb.req_ready, 1);
      check({tag, "_a_rsp_valid"}, ifa.rsp_valid, 0);
      check({tag, "_a_busy"}, ifa.busy, 0);
      check({tag, "_b_busy"}, ifb.busy, 0);
   endtask

   task automatic run_txn(input txn_t t, input int abort_at, input logic check_spacing);
      logic [7:0] eb;
      check("a_req_ready_idle", ifa.req_ready, 1);
      check("b_req_ready_idle", ifb.req_ready, 1);
      drive_req(1'b1, t.data, t.wgt);
      model_hi = t.hi;
      model_lo = t.lo;
      set_rsp_ready(t.bp == 0);
      step();
      // Inputs change after the accept edge; only the sampled vectors may be emitted.
      drive_req(1'b0, ~t.data, ~t.wgt);
      if (check_spacing) check("accept_spacing", tick - acc_tick, 15);
      acc_tick = tick;
      for (int c = 1; c <= 8; c++) begin
         eb = (c <= 4) ? t.exp_d[31 - 8*(c-1) -: 8] : t.exp_w[31 - 8*(c-5) -: 8];
         check($sformatf("a_sel_c%0d", c), ifa.bus_sel, exp_sel(c, RL_A, RDL_A));
         check($sformatf("b_sel_c%0d", c), ifb.bus_sel, exp_sel(c, RL_B, RDL_B));
         check($sformatf("a_byte_c%0d", c), ifa.bus_out, eb);
         check($sformatf("b_byte_c%0d", c), ifb.bus_out, eb);
         check("a_busy", ifa.busy, 1);
         if (c == abort_at) begin
            #2 rst = 1'b1;
            #1 check_reset_outputs("abort");
            check("abort_a_rsp_result", ifa.rsp_result, 0);
            step();
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
               check("post_abort_a_sel", ifa.bus_sel, SEL_IDLE);
               check("post_abort_b_sel", ifb.bus_sel, SEL_IDLE);
               check("post_abort_a_busy", ifa.busy, 0);
               step();
            end
            return;
         end
         step();
      end
      for (int c = 9; c <= 13; c++) begin
         check($sformatf("a_sel_c%0d", c), ifa.bus_sel, exp_sel(c, RL_A, RDL_A));
         check($sformatf("b_sel_c%0d", c), ifb.bus_sel, exp_sel(c, RL_B, RDL_B));
         check("a_rsp_valid_early", ifa.rsp_valid, 0);
         check("b_rsp_valid_early", ifb.rsp_valid, 0);
         step();
      end
      check("a_rsp_valid_c14", ifa.rsp_valid, 1);
      check("b_rsp_valid_c14", ifb.rsp_valid, 1);
      check("a_rsp_result", ifa.rsp_result, t.exp_res);
      check("b_rsp_result", ifb.rsp_result, t.exp_res);
      check("a_sel_resp", ifa.bus_sel, SEL_IDLE);
      check("a_req_ready_resp", ifa.req_ready, 0);
      if (t.bp > 0) begin
         for (int j = 1; j <= t.bp; j++) begin
            drive_req(1'b1, t.wgt, t.data);
            step();
            check("bp_a_rsp_valid", ifa.rsp_valid, 1);
            check("bp_b_rsp_valid", ifb.rsp_valid, 1);
            check("bp_a_rsp_result", ifa.rsp_result, t.exp_res);
            check("bp_b_rsp_result", ifb.rsp_result, t.exp_res);
            check("bp_a_req_ready", ifa.req_ready, 0);
            check("bp_a_sel", ifa.bus_sel, SEL_IDLE);
         end
         drive_req(1'b0, t.wgt, t.data);
         set_rsp_ready(1'b1);
      end
      step();
      check("a_req_ready_after", ifa.req_ready, 1);
      check("b_req_ready_after", ifb.req_ready, 1);
      check("a_rsp_valid_after", ifa.rsp_valid, 0);
      check("a_busy_after", ifa.busy, 0);
      set_rsp_ready(1'b1);
   endtask

   initial begin
      // data lanes {4,3,2,1}, weights all 1
      tbl[0] = '{data: 28'h080C101, wgt: 28'h0204081, hi: 8'h12, lo: 8'h34,
                 exp_d: 32'h0080C101, exp_w: 32'h00204081, exp_res: 16'h1234, bp: 0};
      // all lanes 127
      tbl[1] = '{data: 28'hFFFFFFF, wgt: 28'hFFFFFFF, hi: 8'hA5, lo: 8'h5A,
                 exp_d: 32'h0FFFFFFF, exp_w: 32'h0FFFFFFF, exp_res: 16'hA55A, bp: 0};
      // data {127,0,85,0}, weights {1,0,0,127}, zero high byte, with backpressure
      tbl[2] = '{data: 28'hFE02A80, wgt: 28'h020007F, hi: 8'h00, lo: 8'hFF,
                 exp_d: 32'h0FE02A80, exp_w: 32'h0020007F, exp_res: 16'h00FF, bp: 5};

      rst = 1'b0;
      drive_req(1'b0, '0, '0);
      set_rsp_ready(1'b1);
      #1 rst = 1'b1;
      #1 check_reset_outputs("reset");
      check("reset_a_rsp_result", ifa.rsp_result, 0);
      check("reset_b_bus_out", ifb.bus_out, 0);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 3; i++) begin
         run_txn(tbl[i], 0, i == 1);
      end

      // abort in SEND_W beat 2 (cycle 7), then a fresh request must restart at data byte 0
      run_txn(tbl[1], 7, 1'b0);
      run_txn(tbl[0], 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
